// File: rtl/adc3664_spi_pkg.sv
// Shared definitions for the ADC3664 3-wire SPI configuration port (master and slave).
// Frame: {rw, 3'b000, addr[11:0], data[7:0]}, MSB first.
package adc3664_spi_pkg;

  localparam int unsigned FRAME_BITS       = 24;
  localparam int unsigned ADDR_W           = 12;
  localparam int unsigned DATA_W           = 8;
  localparam logic        RW_READ          = 1'b1;
  // Number of frame bits the master drives on a read before handing SDIO to the slave.
  localparam int unsigned READ_RELEASE_BIT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic              f_rw,
                                                        input logic [ADDR_W-1:0] f_addr,
                                                        input logic [DATA_W-1:0] f_data);
    return {f_rw, 3'b000, f_addr, f_data};
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timebase for the SPI master.
// Ports:
//   CLK      - system clock
//   Reset_n  - asynchronous active-low reset
//   i_en     - count enable; counter is held at zero while low
//   o_tick   - one-cycle pulse every CLK_DIV enabled cycles (end of each SCLK half-period)
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  assign o_tick = i_en && (r_cnt == CntW'(CLK_DIV - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_en || o_tick) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/adc3664_spi_master.sv
// Controller end of the ADC3664 3-wire SPI configuration port.
// One request (rw, addr, wdata) becomes one 24-bit frame on SCLK/SEN/SDIO.
// Ports:
//   CLK, Reset_n  - system clock, asynchronous active-low reset
//   start         - request strobe, accepted only in idle outside the done cycle
//   rw/addr/wdata - request fields, captured with start (1 = read)
//   busy          - high from the cycle after acceptance until done
//   done          - one-cycle pulse at the end of a transaction
//   rdata         - last read data, updated in the done cycle of a read
//   SCLK, SEN     - serial clock (idles low), active-low frame enable (idles high)
//   SDIO          - bidirectional data, Hi-Z when not driven
module adc3664_spi_master
  import adc3664_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              SCLK,
  output logic              SEN,
  inout  wire               SDIO
);

  localparam int unsigned BitCntW = 5;

  spi_state_e r_state, w_state_nxt;

  logic [BitCntW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_tx, w_tx_nxt;
  logic [DATA_W-1:0]     r_rx, w_rx_nxt;
  logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_sen, w_sen_nxt;
  logic                  r_sdio, w_sdio_nxt;
  logic                  r_sdio_oe, w_sdio_oe_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  logic                  w_tick;
  logic                  w_accept;
  logic                  w_sdio_in;
  logic [FRAME_BITS-1:0] w_frame;

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .i_en   (r_state != StIdle),
    .o_tick (w_tick)
  );

  // The done cycle is already idle; r_done keeps a start there from being taken.
  assign w_accept  = (r_state == StIdle) && start && !r_done;
  assign w_frame   = build_frame(rw, addr, wdata);
  assign w_sdio_in = SDIO;

  assign SDIO  = r_sdio_oe ? r_sdio : 1'bz;
  assign SCLK  = r_sclk;
  assign SEN   = r_sen;
  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StSetup;
      StSetup: if (w_tick) w_state_nxt = StShift;
      StShift: begin
        if (w_tick && r_sclk && (r_bit_cnt == BitCntW'(FRAME_BITS - 1))) begin
          w_state_nxt = StHold;
        end
      end
      StHold:  if (w_tick) w_state_nxt = StGap;
      StGap:   if (w_tick && r_bit_cnt[0]) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output / datapath next values; every pin-facing signal is registered.
  // r_bit_cnt counts completed falling edges in SHIFT and half-periods in GAP.
  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rdata_nxt   = r_rdata;
    w_rw_nxt      = r_rw;
    w_sclk_nxt    = r_sclk;
    w_sen_nxt     = r_sen;
    w_sdio_nxt    = r_sdio;
    w_sdio_oe_nxt = r_sdio_oe;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_busy_nxt    = 1'b1;
          w_sen_nxt     = 1'b0;
          w_sdio_oe_nxt = 1'b1;
          w_sdio_nxt    = w_frame[FRAME_BITS-1];
          w_tx_nxt      = w_frame;
          w_rw_nxt      = rw;
          w_bit_cnt_nxt = '0;
          w_rx_nxt      = '0;
        end
      end
      StSetup: begin
        if (w_tick) w_sclk_nxt = 1'b1;
      end
      StShift: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
            // Rising edges 17..24 carry the slave's data byte.
            if ((r_rw == RW_READ) && (r_bit_cnt >= BitCntW'(READ_RELEASE_BIT))) begin
              w_rx_nxt = {r_rx[DATA_W-2:0], w_sdio_in};
            end
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt == BitCntW'(FRAME_BITS - 1)) begin
              w_bit_cnt_nxt = '0;
              w_sdio_oe_nxt = 1'b0;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BitCntW'(1);
              w_sdio_nxt    = r_tx[FRAME_BITS-2];
              w_tx_nxt      = {r_tx[FRAME_BITS-2:0], 1'b0};
              if ((r_rw == RW_READ) && (r_bit_cnt == BitCntW'(READ_RELEASE_BIT - 1))) begin
                w_sdio_oe_nxt = 1'b0;
              end
            end
          end
        end
      end
      StHold: begin
        if (w_tick) w_sen_nxt = 1'b1;
      end
      StGap: begin
        if (w_tick) begin
          if (!r_bit_cnt[0]) begin
            w_bit_cnt_nxt = BitCntW'(1);
          end else begin
            w_done_nxt = 1'b1;
            w_busy_nxt = 1'b0;
            if (r_rw == RW_READ) w_rdata_nxt = r_rx;
          end
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
      r_rw      <= 1'b0;
      r_sclk    <= 1'b0;
      r_sen     <= 1'b1;
      r_sdio    <= 1'b0;
      r_sdio_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rw      <= w_rw_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sen     <= w_sen_nxt;
      r_sdio    <= w_sdio_nxt;
      r_sdio_oe <= w_sdio_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

endmodule
